// File: rtl/compress_stage2.sv
// ---------------------------------------------------------------------------
// compress_stage2
//
// Second half of a two-rounds-per-cycle SHA-256 compression datapath. The
// upstream stage supplies pre-added partial sums (p1..p5) and the forwarded
// state words a, b, e, f of round t. This block finishes round t, runs round
// t+1, and presents the complete working state a..h. It is an elastic
// valid/ready pipeline with a round-pair counter that tags every bundle.
//
// Optional feature macro: COMPRESS2_INREG_EN
//   defined   : input register stage R1 present, accept-to-valid latency 2
//   undefined : R1 removed, the input bundle feeds R2 directly, latency 1
//
// Ports
//   clk                   rising-edge clock
//   rst                   synchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_first              bundle is round pair 0 of a new message block
//   a_in, b_in, e_in, f_in  forwarded state words of round t
//   p1..p5                pre-added partial sums from the first stage
//   out_valid / out_ready output handshake
//   a_out..h_out          working state after round t+1
//   pair_idx              round-pair index of the output (0..31)
//   out_last              pair_idx == 31
// ---------------------------------------------------------------------------
module compress_stage2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_first,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] e_in,
  input  logic [31:0] f_in,
  input  logic [31:0] p1,
  input  logic [31:0] p2,
  input  logic [31:0] p3,
  input  logic [31:0] p4,
  input  logic [31:0] p5,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out,
  output logic [31:0] e_out,
  output logic [31:0] f_out,
  output logic [31:0] g_out,
  output logic [31:0] h_out,
  output logic [4:0]  pair_idx,
  output logic        out_last
);

  // Positions of the words inside the bundle array.
  localparam int NW   = 9;
  localparam int W_A  = 0;
  localparam int W_B  = 1;
  localparam int W_E  = 2;
  localparam int W_F  = 3;
  localparam int W_P1 = 4;
  localparam int W_P2 = 5;
  localparam int W_P3 = 6;
  localparam int W_P4 = 7;
  localparam int W_P5 = 8;

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // -------------------------------------------------------------------------
  // Input bundle and round-pair tagging
  // -------------------------------------------------------------------------
  logic [31:0] in_words [NW];
  logic [4:0]  cnt_reg;
  logic [4:0]  in_tag;
  logic        in_accept;

  assign in_words[W_A]  = a_in;
  assign in_words[W_B]  = b_in;
  assign in_words[W_E]  = e_in;
  assign in_words[W_F]  = f_in;
  assign in_words[W_P1] = p1;
  assign in_words[W_P2] = p2;
  assign in_words[W_P3] = p3;
  assign in_words[W_P4] = p4;
  assign in_words[W_P5] = p5;

  // in_first restarts numbering at 0 even in the middle of a message.
  assign in_tag    = in_first ? 5'd0 : cnt_reg;
  assign in_accept = in_valid && in_ready;

  // The 5-bit add wraps 31 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 5'd0;
    end else if (in_accept) begin
      cnt_reg <= in_tag + 5'd1;
    end
  end

  // -------------------------------------------------------------------------
  // R2 load condition: empty, or its current contents leave this cycle.
  // -------------------------------------------------------------------------
  logic r2_valid_reg;
  logic r2_load;

  assign r2_load = !r2_valid_reg || out_ready;

  // Source of the R2 datapath: either the R1 register or the raw inputs.
  logic [31:0] src_words [NW];
  logic        src_valid;
  logic [4:0]  src_tag;

`ifdef COMPRESS2_INREG_EN
  logic [31:0] r1_words_reg [NW];
  logic        r1_valid_reg;
  logic [4:0]  r1_tag_reg;

  // R1 moves whenever R2 can take its contents, so in_ready only looks at
  // register state and out_ready, never at in_valid.
  assign in_ready = !r1_valid_reg || r2_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid_reg <= 1'b0;
      r1_tag_reg   <= 5'd0;
      for (int i = 0; i < NW; i++) begin
        r1_words_reg[i] <= 32'd0;
      end
    end else if (in_ready) begin
      r1_valid_reg <= in_valid;
      if (in_valid) begin
        r1_tag_reg <= in_tag;
        for (int i = 0; i < NW; i++) begin
          r1_words_reg[i] <= in_words[i];
        end
      end
    end
  end

  assign src_words = r1_words_reg;
  assign src_valid = r1_valid_reg;
  assign src_tag   = r1_tag_reg;
`else
  assign in_ready  = r2_load;
  assign src_words = in_words;
  assign src_valid = in_valid;
  assign src_tag   = in_tag;
`endif

  // -------------------------------------------------------------------------
  // Round t completion and round t+1
  // -------------------------------------------------------------------------
  logic [31:0] a1;
  logic [31:0] e1;
  logic [31:0] t_shared;
  logic [31:0] a_next;
  logic [31:0] e_next;

  assign a1 = src_words[W_P3] + src_words[W_P1];
  assign e1 = src_words[W_P2];

  // Σ1(e1)+Ch(e1,e,f) is common to the new a (via p4) and the new e (via p5,
  // which already carries the +c that turns T1 into the new e).
  assign t_shared = big_sigma1(e1) + ch(e1, src_words[W_E], src_words[W_F]);
  assign a_next   = src_words[W_P4] + t_shared + big_sigma0(a1)
                  + maj(a1, src_words[W_A], src_words[W_B]);
  assign e_next   = src_words[W_P5] + t_shared;

  // -------------------------------------------------------------------------
  // R2 output register. Data only changes when a valid bundle is loaded, so
  // the outputs are stable while stalled.
  // -------------------------------------------------------------------------
  logic [31:0] a_reg, b_reg, c_reg, d_reg, e_reg, f_reg, g_reg, h_reg;
  logic [4:0]  pair_idx_reg;
  logic        out_last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid_reg <= 1'b0;
      a_reg        <= 32'd0;
      b_reg        <= 32'd0;
      c_reg        <= 32'd0;
      d_reg        <= 32'd0;
      e_reg        <= 32'd0;
      f_reg        <= 32'd0;
      g_reg        <= 32'd0;
      h_reg        <= 32'd0;
      pair_idx_reg <= 5'd0;
      out_last_reg <= 1'b0;
    end else if (r2_load) begin
      r2_valid_reg <= src_valid;
      if (src_valid) begin
        a_reg        <= a_next;
        b_reg        <= a1;
        c_reg        <= src_words[W_A];
        d_reg        <= src_words[W_B];
        e_reg        <= e_next;
        f_reg        <= e1;
        g_reg        <= src_words[W_E];
        h_reg        <= src_words[W_F];
        pair_idx_reg <= src_tag;
        out_last_reg <= (src_tag == 5'd31);
      end
    end
  end

  assign out_valid = r2_valid_reg;
  assign a_out     = a_reg;
  assign b_out     = b_reg;
  assign c_out     = c_reg;
  assign d_out     = d_reg;
  assign e_out     = e_reg;
  assign f_out     = f_reg;
  assign g_out     = g_reg;
  assign h_out     = h_reg;
  assign pair_idx  = pair_idx_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_compress_stage2.sv
// ---------------------------------------------------------------------------
// tb_compress_stage2
//
// Self-checking bench for compress_stage2. Bundles are generated from a full
// eight-word SHA-256 state plus W/K words; the expected output is that state
// advanced by two plain SHA-256 rounds. Tags come from a counter model of the
// round-pair numbering. A negedge monitor scoreboards every output transfer
// and checks output stability during stalls.
// Build with or without COMPRESS2_INREG_EN; expected latency follows it.
// ---------------------------------------------------------------------------
module tb_compress_stage2;

`ifdef COMPRESS2_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0]      a, b, e, f, p1, p2, p3, p4, p5;
    bit               first;
    logic [7:0][31:0] x;      // expected a..h after both rounds
  } bundle_t;

  typedef struct {
    logic [7:0][31:0] x;
    logic [4:0]       idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [31:0] a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;
  logic [4:0]  pair_idx;
  logic        out_last;
  bundle_t     drv;

  always #5 clk = ~clk;

  compress_stage2 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (drv.first),
    .a_in      (drv.a),
    .b_in      (drv.b),
    .e_in      (drv.e),
    .f_in      (drv.f),
    .p1        (drv.p1),
    .p2        (drv.p2),
    .p3        (drv.p3),
    .p4        (drv.p4),
    .p5        (drv.p5),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .d_out     (d_out),
    .e_out     (e_out),
    .f_out     (f_out),
    .g_out     (g_out),
    .h_out     (h_out),
    .pair_idx  (pair_idx),
    .out_last  (out_last)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [262:0] got, input logic [262:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference SHA-256 primitives ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] fch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic logic [31:0] fmaj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // One textbook SHA-256 round; index 0 = a ... 7 = h.
  function automatic logic [7:0][31:0] sha_round(input logic [7:0][31:0] s,
                                                  input logic [31:0] k, input logic [31:0] w);
    logic [7:0][31:0] r;
    logic [31:0] t1, t2;
    t1 = s[7] + bs1(s[4]) + fch(s[4], s[5], s[6]) + k + w;
    t2 = bs0(s[0]) + fmaj(s[0], s[1], s[2]);
    r[0] = t1 + t2;
    r[1] = s[0];
    r[2] = s[1];
    r[3] = s[2];
    r[4] = s[3] + t1;
    r[5] = s[4];
    r[6] = s[5];
    r[7] = s[6];
    return r;
  endfunction

  // Forms what the first stage would hand over, plus the two-round result.
  function automatic bundle_t from_state(input logic [7:0][31:0] s,
                                         input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] k0, input logic [31:0] k1,
                                         input bit first);
    bundle_t b;
    b.a  = s[0];
    b.b  = s[1];
    b.e  = s[4];
    b.f  = s[5];
    b.p1 = bs0(s[0]) + fmaj(s[0], s[1], s[2]);
    b.p3 = s[7] + w0 + k0 + bs1(s[4]) + fch(s[4], s[5], s[6]);
    b.p2 = b.p3 + s[3];
    b.p4 = w1 + k1 + s[6];
    b.p5 = b.p4 + s[2];
    b.first = first;
    b.x  = sha_round(sha_round(s, k0, w0), k1, w1);
    return b;
  endfunction

  function automatic bundle_t rand_bundle(input bit first);
    logic [7:0][31:0] s;
    for (int i = 0; i < 8; i++) s[i] = $urandom;
    return from_state(s, $urandom, $urandom, $urandom, $urandom, first);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  exp_t        q[$];
  logic [4:0]  seen_idx[$];
  bit          seen_last[$];
  logic [4:0]  mcnt;
  logic [262:0] snap;
  bit          have_snap;
  bit          saw_full;
  exp_t        ex;
  logic [4:0]  tag;
  logic [7:0][31:0] got_w;

  always @(negedge clk) begin
    got_w = {h_out, g_out, f_out, e_out, d_out, c_out, b_out, a_out};
    if (rst) begin
      q.delete();
      mcnt      = 5'd0;
      have_snap = 1'b0;
    end else begin
      if (have_snap)
        check_wide("stall_hold", {out_valid, got_w, pair_idx, out_last}, snap);
      have_snap = 1'b0;
      if (out_valid && !out_ready) begin
        snap      = {out_valid, got_w, pair_idx, out_last};
        have_snap = 1'b1;
      end
      if (in_valid && !in_ready) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          ex = q.pop_front();
          for (int i = 0; i < 8; i++)
            check($sformatf("word%0d", i), 64'(got_w[i]), 64'(ex.x[i]));
          check("pair_idx", 64'(pair_idx), 64'(ex.idx));
          check("out_last", 64'(out_last), 64'(ex.idx == 5'd31));
        end
        seen_idx.push_back(pair_idx);
        seen_last.push_back(out_last);
      end
      if (in_valid && in_ready) begin
        tag     = drv.first ? 5'd0 : mcnt;
        mcnt    = tag + 5'd1;
        ex.x    = drv.x;
        ex.idx  = tag;
        q.push_back(ex);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver, updated just after the main driver so mode changes
  // written at posedge+1 apply to the same cycle.
  int omode     = 0;   // 0: high, 1: random, 2: low
  int stall_cnt = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        case (omode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b0;
        endcase
      end
    end
  end

  // Presents b and waits (bounded) for the accept; returns at posedge+1.
  task automatic send(input bundle_t b, input int max_wait, output bit ok);
    drv      = b;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    omode = 0;
    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  bundle_t b;
  bit ok;
  int n;
  int c0;
  logic [7:0][31:0] iv;
  bit firsts [9] = '{1, 0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    drv       = rand_bundle(1'b0);
    mcnt      = 5'd0;
    have_snap = 1'b0;
    saw_full  = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_a_out", 64'(a_out), 64'd0);
    check("post_rst_pair_idx", 64'(pair_idx), 64'd0);
    check("post_rst_out_last", 64'(out_last), 64'd0);
    @(posedge clk);
    #1;

    // ---- FIPS "abc" rounds 0/1, latency ----
    iv[0] = 32'h6A09E667; iv[1] = 32'hBB67AE85; iv[2] = 32'h3C6EF372; iv[3] = 32'hA54FF53A;
    iv[4] = 32'h510E527F; iv[5] = 32'h9B05688C; iv[6] = 32'h1F83D9AB; iv[7] = 32'h5BE0CD19;
    b = from_state(iv, 32'h61626380, 32'h00000000, 32'h428A2F98, 32'h71374491, 1'b1);
    send(b, 20, ok);
    check("abc_accept", 64'(ok), 64'd1);
    @(negedge clk);
    n = 1;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    $display("[TB] abc bundle: latency %0d a=%08h e=%08h", n, a_out, e_out);
    check("latency", 64'(n), 64'(LAT));
    check("abc_a", 64'(a_out), 64'h5A6AD9AD);
    check("abc_b", 64'(b_out), 64'h5D6AEBCD);
    check("abc_c", 64'(c_out), 64'h6A09E667);
    check("abc_d", 64'(d_out), 64'hBB67AE85);
    check("abc_e", 64'(e_out), 64'h78CE7989);
    check("abc_f", 64'(f_out), 64'hFA2A4622);
    check("abc_g", 64'(g_out), 64'h510E527F);
    check("abc_h", 64'(h_out), 64'h9B05688C);
    check("abc_pair_idx", 64'(pair_idx), 64'd0);
    check("abc_out_last", 64'(out_last), 64'd0);
    drain();

    // ---- 33 back-to-back bundles ----
    seen_idx.delete();
    seen_last.delete();
    c0 = cyc;
    for (int i = 0; i < 33; i++) begin
      send(rand_bundle(i == 0), 4, ok);
      check("burst_accept", 64'(ok), 64'd1);
    end
    check("burst_cycles", 64'(cyc - c0), 64'd33);
    drain();
    check("burst_count", 64'(seen_idx.size()), 64'd33);
    if (seen_idx.size() == 33) begin
      n = 0;
      for (int i = 0; i < 33; i++) n += int'(seen_last[i]);
      $display("[TB] burst: idx31=%0d idx32=%0d lasts=%0d", seen_idx[31], seen_idx[32], n);
      check("burst_idx0", 64'(seen_idx[0]), 64'd0);
      check("burst_idx31", 64'(seen_idx[31]), 64'd31);
      check("burst_last31", 64'(seen_last[31]), 64'd1);
      check("burst_idx32", 64'(seen_idx[32]), 64'd0);
      check("burst_last_count", 64'(n), 64'd1);
    end

    // ---- backpressure: out_ready low 5 cycles, in_valid held ----
    saw_full  = 1'b0;
    stall_cnt = 5;
    for (int i = 0; i < 8; i++) begin
      send(rand_bundle(1'b0), 20, ok);
      check("stall_accept", 64'(ok), 64'd1);
    end
    $display("[TB] stall: saw_full=%0d", saw_full);
    check("stall_in_ready_dropped", 64'(saw_full), 64'd1);
    drain();

    // ---- in_first restart at tag 7 ----
    seen_idx.delete();
    for (int i = 0; i < 9; i++) begin
      send(rand_bundle(firsts[i]), 10, ok);
      check("restart_accept", 64'(ok), 64'd1);
    end
    drain();
    check("restart_count", 64'(seen_idx.size()), 64'd9);
    if (seen_idx.size() == 9) begin
      $display("[TB] restart: idx6=%0d idx7=%0d idx8=%0d", seen_idx[6], seen_idx[7], seen_idx[8]);
      check("restart_idx6", 64'(seen_idx[6]), 64'd6);
      check("restart_idx7", 64'(seen_idx[7]), 64'd0);
      check("restart_idx8", 64'(seen_idx[8]), 64'd1);
    end

    // ---- reset with both stages full ----
    omode = 2;
    for (int i = 0; i < 3; i++) send(rand_bundle(1'b0), 2, ok);
    @(negedge clk);
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    $display("[TB] mid reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_a_out", 64'(a_out), 64'd0);
    check("midrst_e_out", 64'(e_out), 64'd0);
    check("midrst_h_out", 64'(h_out), 64'd0);
    @(posedge clk);
    #1 omode = 0;
    seen_idx.delete();
    send(rand_bundle(1'b0), 10, ok);
    check("midrst_accept", 64'(ok), 64'd1);
    drain();
    check("midrst_count", 64'(seen_idx.size()), 64'd1);
    if (seen_idx.size() == 1) check("midrst_first_idx", 64'(seen_idx[0]), 64'd0);

    // ---- all-ones operands, mod 2^32 wrap (hand-derived result) ----
    b.a = '1; b.b = '1; b.e = '1; b.f = '1;
    b.p1 = '1; b.p2 = '1; b.p3 = '1; b.p4 = '1; b.p5 = '1;
    b.first = 1'b0;
    b.x[0] = 32'hBFF7FBFB; b.x[1] = 32'hFFFFFFFE; b.x[2] = 32'hFFFFFFFF; b.x[3] = 32'hFFFFFFFF;
    b.x[4] = 32'hFFFFFFFD; b.x[5] = 32'hFFFFFFFF; b.x[6] = 32'hFFFFFFFF; b.x[7] = 32'hFFFFFFFF;
    send(b, 10, ok);
    check("ones_accept", 64'(ok), 64'd1);
    drain();

    // ---- randomized traffic with random backpressure ----
    omode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(rand_bundle($urandom_range(0, 15) == 0), 50, ok);
      check("rand_accept", 64'(ok), 64'd1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
